conv3x3_kernel_filter: RTL

//  Parametrised 3x3 convolution filter with a programmable signed kernel and a programmable normalising right-shift.

---
 rtl/conv3x3_kernel_filter.sv | 101 ++++++++++
 1 files changed

// File: rtl/conv3x3_kernel_filter.sv
// conv3x3_kernel_filter: 3x3 signed-kernel convolution with normalising shift and clamp, 3-stage ready/valid pipeline.
// Optional CONV3X3_ROUND_EN: round half up before the shift instead of truncating.
module conv3x3_kernel_filter #(
  parameter int CH_W   = 4,
  parameter int N_CH   = 3,
  parameter int COEF_W = 8,
  parameter int PIX_W  = N_CH * CH_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [9*PIX_W-1:0]   window_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_W-1:0]     pix_out,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [COEF_W-1:0]    cfg_data,
  input  logic                 cfg_commit
);
  localparam int ACC_W = CH_W + COEF_W + 5;
  localparam int PR_W  = CH_W + 1 + COEF_W;

  logic signed [COEF_W-1:0] sh_coef_q [9];
  logic signed [COEF_W-1:0] ac_coef_q [9];
  logic signed [COEF_W-1:0] s1_coef_q [9];
  logic [3:0] sh_shift_q, ac_shift_q, s1_shift_q, s2_shift_q;
  logic [9*PIX_W-1:0] s1_taps_q;
  logic signed [PR_W-1:0] prod_d [N_CH][9];
  logic signed [PR_W-1:0] prod_q [N_CH][9];
  logic s1_v_q, s2_v_q, en;
  logic [PIX_W-1:0] pix_d;
  logic signed [ACC_W-1:0] acc, acc_sh;

  assign en       = !out_valid | out_ready;
  assign in_ready = en;

  // Commit samples the shadow before any same-edge write lands, so it copies the pre-write value.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      for (int i = 0; i < 9; i++) begin
        sh_coef_q[i] <= (i == 4) ? COEF_W'(1) : '0;
        ac_coef_q[i] <= (i == 4) ? COEF_W'(1) : '0;
      end
      sh_shift_q <= '0;
      ac_shift_q <= '0;
    end else begin
      if (cfg_we && cfg_addr < 4'd9) sh_coef_q[cfg_addr] <= cfg_data;
      if (cfg_we && cfg_addr == 4'd9) sh_shift_q <= cfg_data[3:0];
      if (cfg_commit) begin
        ac_coef_q  <= sh_coef_q;
        ac_shift_q <= sh_shift_q;
      end
    end

  always_comb
    for (int c = 0; c < N_CH; c++)
      for (int t = 0; t < 9; t++)
        prod_d[c][t] = PR_W'($signed({1'b0, s1_taps_q[t*PIX_W + c*CH_W +: CH_W]})) * PR_W'(s1_coef_q[t]);

  always_comb begin
    pix_d  = '0;
    acc    = '0;
    acc_sh = '0;
    for (int c = 0; c < N_CH; c++) begin
      acc = '0;
      for (int t = 0; t < 9; t++) acc = acc + ACC_W'(prod_q[c][t]);
`ifdef CONV3X3_ROUND_EN
      if (s2_shift_q != 4'd0) acc = acc + (ACC_W'(1) << (s2_shift_q - 4'd1));
`endif
      acc_sh = acc >>> s2_shift_q;
      pix_d[c*CH_W +: CH_W] = (acc_sh < 0) ? '0 : (acc_sh > ACC_W'((1 << CH_W) - 1)) ? '1 : acc_sh[CH_W-1:0];
    end
  end

  // Each beat carries its own kernel snapshot so a commit never disturbs beats already in flight.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      s1_v_q     <= 1'b0;
      s2_v_q     <= 1'b0;
      out_valid  <= 1'b0;
      pix_out    <= '0;
      s1_taps_q  <= '0;
      s1_shift_q <= '0;
      s2_shift_q <= '0;
      for (int i = 0; i < 9; i++) s1_coef_q[i] <= '0;
      for (int c = 0; c < N_CH; c++)
        for (int t = 0; t < 9; t++) prod_q[c][t] <= '0;
    end else if (en) begin
      s1_v_q     <= in_valid;
      s1_taps_q  <= window_in;
      s1_coef_q  <= ac_coef_q;
      s1_shift_q <= ac_shift_q;
      s2_v_q     <= s1_v_q;
      prod_q     <= prod_d;
      s2_shift_q <= s1_shift_q;
      out_valid  <= s2_v_q;
      pix_out    <= pix_d;
    end
endmodule
